// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register load/shift sequencer.
package shift_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam int DEF_WIDTH = 4;
   localparam int CNT_W     = 8;
endpackage

// File: rtl/shift_seq_buf.sv
// Word buffer for the sequencer: 2-entry FIFO with SHIFT_SEQUENCER_FIFO2_EN, else one holding register.
// Push and pop may coincide; full never blocks a push that lands on a pop.
module shift_seq_buf
   import shift_pkg::*;
#(
   parameter int W = DEF_WIDTH + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty,
   output logic         more
);

`ifdef SHIFT_SEQUENCER_FIFO2_EN
   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic [1:0]   cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               // count is unchanged; the pending entry moves up behind the new word
               if (cnt == 2'd2) begin
                  e0 <= e1;
                  e1 <= wr;
               end else begin
                  e0 <= wr;
               end
            end
            2'b10: begin
               if (cnt == 2'd0) e0 <= wr;
               else             e1 <= wr;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign head  = e0;
   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);
   assign more  = (cnt == 2'd2);
`else
   logic [W-1:0] e0;
   logic         vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         vld <= 1'b0;
      end else if (push) begin
         e0  <= wr;
         vld <= 1'b1;
      end else if (pop) begin
         vld <= 1'b0;
      end
   end

   assign head  = e0;
   assign full  = vld;
   assign empty = ~vld;
   assign more  = 1'b0;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Drives LD/SHFT/InP/InS of a right-shift register: LOAD 1 cycle, SHIFT SHIFT_COUNT cycles, DONE 1 cycle per word.
// Buffer depth set by SHIFT_SEQUENCER_FIFO2_EN; in_ready = not full, or the DONE cycle that frees a slot.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SHIFT_COUNT = 4
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_fill,
   output logic             in_ready,
   output logic             LD,
   output logic             SHFT,
   output logic [WIDTH-1:0] InP,
   output logic             InS,
   output logic             busy,
   output logic             done
);

   state_t             state;
   state_t             nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   inp_q;
   logic [WIDTH:0]     head;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               more;

   assign pop      = (state == DONE);
   assign in_ready = ~full | pop;
   assign push     = in_valid & in_ready;

   shift_seq_buf #(.W(WIDTH + 1)) u_buf (
      .clk   (CLK),
      .rst   (Clear),
      .push  (push),
      .pop   (pop),
      .wr    ({in_fill, in_data}),
      .head  (head),
      .full  (full),
      .empty (empty),
      .more  (more)
   );

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state <= IDLE;
         cnt   <= '0;
         inp_q <= '0;
      end else begin
         state <= nxt;
         if (state == LOAD)
            cnt <= CNT_W'(SHIFT_COUNT - 1);
         else if (state == SHIFT && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == LOAD)
            inp_q <= head[WIDTH-1:0];
      end
   end

   always_comb begin
      nxt  = state;
      LD   = 1'b0;
      SHFT = 1'b0;
      InP  = inp_q;
      InS  = 1'b0;
      busy = (state != IDLE);
      done = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) nxt = LOAD;
         end
         LOAD: begin
            LD  = 1'b1;
            InP = head[WIDTH-1:0];
            nxt = SHIFT;
         end
         SHIFT: begin
            SHFT = 1'b1;
            InS  = head[WIDTH];
            if (cnt == '0) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            // a word pushed in this same cycle counts as buffered
            nxt  = (more || push) ? LOAD : IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized plus directed bench for shift_sequencer (SHIFT_COUNT 4 and 1) against a phase-based word model.
module tb_shift_sequencer;

`ifdef SHIFT_SEQUENCER_FIFO2_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam int N0 = 4;
   localparam int N1 = 1;

   logic       CLK = 1'b0;
   logic       Clear = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'd0;
   logic       in_fill = 1'b0;

   logic       rdy0, ld0, sh0, ins0, busy0, dn0;
   logic [3:0] inp0;
   logic       rdy1, ld1, sh1, ins1, busy1, dn1;
   logic [3:0] inp1;

   always #5 CLK = ~CLK;

   shift_sequencer #(.WIDTH(4), .SHIFT_COUNT(N0)) dut (
      .CLK(CLK), .Clear(Clear), .in_valid(in_valid), .in_data(in_data), .in_fill(in_fill),
      .in_ready(rdy0), .LD(ld0), .SHFT(sh0), .InP(inp0), .InS(ins0), .busy(busy0), .done(dn0)
   );

   shift_sequencer #(.WIDTH(4), .SHIFT_COUNT(N1)) dut1 (
      .CLK(CLK), .Clear(Clear), .in_valid(in_valid), .in_data(in_data), .in_fill(in_fill),
      .in_ready(rdy1), .LD(ld1), .SHFT(sh1), .InP(inp1), .InS(ins1), .busy(busy1), .done(dn1)
   );

   // Model: buffered words plus the phase of the word in service
   // (phase 0 = load, 1..n = shift, n+1 = done).
   typedef struct packed {
      logic       act;
      logic [8:0] ph;
      logic [1:0] cnt;
      logic [4:0] b0;
      logic [4:0] b1;
      logic [3:0] last;
   } mst_t;

   mst_t ms0 = '0;
   mst_t ms1 = '0;

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [9:0] m_out(mst_t s, int n);
      logic ld, sh, dn, rdy, ins;
      logic [3:0] inp;
      ld  = s.act && (int'(s.ph) == 0);
      sh  = s.act && (int'(s.ph) >= 1) && (int'(s.ph) <= n);
      dn  = s.act && (int'(s.ph) == n + 1);
      rdy = (int'(s.cnt) < CAP) || dn;
      inp = ld ? s.b0[3:0] : s.last;
      ins = sh && s.b0[4];
      return {rdy, ld, sh, inp, ins, s.act, dn};
   endfunction

   function automatic mst_t m_next(mst_t s, int n, logic vld, logic [4:0] w);
      logic [9:0] o;
      logic acc;
      mst_t r;
      o   = m_out(s, n);
      acc = vld && o[9];
      r   = s;
      if (o[8]) r.last = s.b0[3:0];
      if (s.act) begin
         if (int'(s.ph) == n + 1) begin
            r.b0  = s.b1;
            r.cnt = s.cnt - 2'd1;
            r.ph  = 9'd0;
            if (r.cnt == 2'd0 && !acc) r.act = 1'b0;
         end else begin
            r.ph = s.ph + 9'd1;
         end
      end else if (s.cnt != 2'd0) begin
         r.act = 1'b1;
         r.ph  = 9'd0;
      end
      if (acc) begin
         if (r.cnt == 2'd0) r.b0 = w;
         else               r.b1 = w;
         r.cnt = r.cnt + 2'd1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK or posedge Clear);
         if (Clear) begin
            ms0 = '0;
            ms1 = '0;
         end else begin
            ms0 = m_next(ms0, N0, in_valid, {in_fill, in_data});
            ms1 = m_next(ms1, N1, in_valid, {in_fill, in_data});
         end
      end
   end

   // Per-cycle compare plus event bookkeeping for the directed checks.
   int cyc = 0;
   int n_ld0 = 0, n_sh0 = 0, n_dn0 = 0, n_acc0 = 0;
   int n_ld1 = 0, n_sh1 = 0, n_dn1 = 0;
   int ld_cyc0 = 0, ld_prev0 = 0, dn_cyc0 = 0, dn_prev0 = 0, acc_cyc0 = 0;
   int ld_cyc1 = 0, dn_cyc1 = 0;
   logic acc_in_dn0 = 1'b0;
   logic dnp0 = 1'b0, dnp1 = 1'b0;
   logic [3:0] sr = 4'd0;

   initial begin
      forever begin
         @(negedge CLK);
         chk("dut_outputs", {22'd0, rdy0, ld0, sh0, inp0, ins0, busy0, dn0}, {22'd0, m_out(ms0, N0)});
         chk("dut1_outputs", {22'd0, rdy1, ld1, sh1, inp1, ins1, busy1, dn1}, {22'd0, m_out(ms1, N1)});
         chk("ld_shft_exclusive", {31'd0, (ld0 & sh0) | (ld1 & sh1)}, 32'd0);
         chk("done_one_cycle", {31'd0, (dn0 & dnp0) | (dn1 & dnp1)}, 32'd0);
         dnp0 = dn0;
         dnp1 = dn1;
         if (ld0) begin
            ld_prev0 = ld_cyc0; ld_cyc0 = cyc; n_ld0++; sr = inp0;
         end else if (sh0) begin
            sr = {ins0, sr[3:1]}; n_sh0++;
         end
         if (dn0) begin dn_prev0 = dn_cyc0; dn_cyc0 = cyc; n_dn0++; end
         if (in_valid && rdy0) begin acc_cyc0 = cyc; n_acc0++; acc_in_dn0 = dn0; end
         if (ld1) begin ld_cyc1 = cyc; n_ld1++; end
         if (sh1) n_sh1++;
         if (dn1) begin dn_cyc1 = cyc; n_dn1++; end
         cyc++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic f);
      logic got;
      got = 1'b0;
      in_valid = 1'b1; in_data = d; in_fill = f;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge CLK);
         got = rdy0;
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      if (!got) chk("push_timeout", 32'd0, 32'd1);
   endtask

   int s_ld, s_sh, s_dn, s_ld1, s_sh1, s_dn1, s_acc, a1, a2;
   logic seen;

   initial begin
      tick(2);
      chk("reset_state", {22'd0, rdy0, ld0, sh0, inp0, ins0, busy0, dn0}, 32'b10_0000_0000);
      Clear = 1'b0;
      tick(1);

      // Scenario 1 (dut) and scenario 4 (dut1, one SHFT per word)
      s_ld = n_ld0; s_sh = n_sh0; s_dn = n_dn0;
      s_ld1 = n_ld1; s_sh1 = n_sh1; s_dn1 = n_dn1;
      push(4'b0101, 1'b1);
      tick(10);
      chk("s1_ld_count", n_ld0 - s_ld, 1);
      chk("s1_shft_count", n_sh0 - s_sh, 4);
      chk("s1_done_count", n_dn0 - s_dn, 1);
      chk("s1_register", {28'd0, sr}, 32'hF);
      chk("s1_latency", ld_cyc0 - acc_cyc0, 2);
      chk("s1_ld_to_done", dn_cyc0 - ld_cyc0, 5);
      chk("s1_inp_hold", {28'd0, inp0}, 32'h5);
      chk("s4_ld_count", n_ld1 - s_ld1, 1);
      chk("s4_shft_count", n_sh1 - s_sh1, 1);
      chk("s4_done_count", n_dn1 - s_dn1, 1);
      chk("s4_ld_to_done", dn_cyc1 - ld_cyc1, 2);

      // Scenario 2: back-to-back words
      push(4'b1010, 1'b0);
      a1 = acc_cyc0;
      push(4'b0011, 1'b1);
      a2 = acc_cyc0;
      tick(16);
`ifdef SHIFT_SEQUENCER_FIFO2_EN
      chk("s2_no_stall", a2 - a1, 1);
`else
      chk("s2_accept_at_done", a2, dn_prev0);
`endif
      chk("s2_ld_after_done", ld_cyc0 - dn_prev0, 1);
      chk("s2_throughput", ld_cyc0 - ld_prev0, 6);
      chk("s2_register", {28'd0, sr}, 32'hF);

      // Scenario 3: Clear during the second SHFT cycle
      push(4'b1100, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge CLK);
         seen = sh0;
      end
      if (!seen) chk("s3_shift_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #2;
      s_dn = n_dn0; s_ld = n_ld0;
      Clear = 1'b1;
      #1;
      chk("s3_clear_immediate", {27'd0, ld0, sh0, busy0, dn0, rdy0}, 32'b00001);
      #5;
      Clear = 1'b0;
      tick(8);
      chk("s3_no_done", n_dn0 - s_dn, 0);
      chk("s3_buffer_empty", n_ld0 - s_ld, 0);
      chk("s3_idle", {30'd0, busy0, rdy0}, 32'b01);

      // Scenario 5: valid held against a full buffer
      s_acc = n_acc0;
      push(4'b0110, 1'b0);
      push(4'b1001, 1'b1);
      push(4'b1111, 1'b0);
      chk("s5_accepts", n_acc0 - s_acc, 3);
      chk("s5_capture_at_done", {31'd0, acc_in_dn0}, 32'd1);
      tick(20);

      // Random traffic with occasional Clear
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            Clear = 1'b1;
            in_valid = 1'b0;
         end else begin
            Clear = 1'b0;
            in_valid = ($urandom_range(0, 2) != 0);
         end
         in_data = 4'($urandom);
         in_fill = 1'($urandom);
         tick(1);
      end
      Clear = 1'b0;
      in_valid = 1'b0;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
